con_ff_logic: RTL and testbench
===============================

# con_ff_logic

Conditional-branch flip-flop (CON FF) for the CPU datapath. During the branch instruction's condition-evaluation step it decodes the C2 condition field of the instruction register. It tests the register value currently on the bus against the selected condition and latches the one-bit result. The control unit reads this result to decide whether the PC is loaded with the branch target.

## Interface
- No parameters. Data width fixed at 32 bits. Condition field fixed at IR[20:19].
- `clock`  in  1  system clock; all state updates on the rising edge.
- `clear`  in  1  reset, synchronous, active-high; clears `ConFFOut`.
- `ConIn`  in  1  load enable; the condition result is registered on the rising edge when it is 1.
- `IRout`  in  32  instruction register contents; only bits [20:19] (C2) are used.
- `BusMuxOut`  in  32  bus value; carries R[Ra] during the evaluation step.
- `ConFFOut`  out  32→1  registered branch decision (1 bit); 1 = take branch.

Reset is synchronous and active-high. There is one clock.

## Operation
- C2 = IRout[20:19] goes through a 2-to-4 one-hot decoder:
  - 00 brzr: condition true when BusMuxOut == 32'h0.
  - 01 brnz: condition true when BusMuxOut != 32'h0.
  - 10 brpl: condition true when BusMuxOut[31] == 0 (non-negative; zero counts as positive).
  - 11 brmi: condition true when BusMuxOut[31] == 1.
- Combinational result = OR over the four (decoder line AND condition) terms.
- Zero detect is the NOR of all 32 bus bits.
- IRout bits other than [20:19] have no effect.
- `ConFFOut` is the output of a D flip-flop:
  - clear = 1: next value 0, regardless of ConIn.
  - else ConIn = 1: next value is the combinational result.
  - else: hold.
- No X propagation from unused IR bits. An X on C2 or on the bus is the caller's responsibility.

## Timing
- Reset value of `ConFFOut`: 0.
- Latency: inputs sampled on the rising edge where ConIn = 1. `ConFFOut` is valid after that edge and stays valid until the next load or clear.
- IRout and BusMuxOut need only be stable around that sampling edge. Changes while ConIn = 0 are ignored.
- clear and ConIn high on the same edge: clear wins, output 0.
- ConIn held high for several edges: reloads every edge and tracks the current inputs.
- Reset asserted mid-branch sequence: output forced to 0 on the next edge, so the branch is not taken.
- No combinational path from inputs to `ConFFOut`.

## Structure
- Shared CPU package constants:
  - C2 encodings: BR_ZR = 2'b00, BR_NZ = 2'b01, BR_PL = 2'b10, BR_MI = 2'b11.
  - IR field positions: C2_HI = 20, C2_LO = 19.
  - DATA_W = 32.
- One sub-module: `decoder_2to4` (2-bit in, 4-bit one-hot out). It is reused elsewhere in the control path.
- The top level contains the zero detect, sign tap, AND-OR select and the flip-flop.

## Test plan
- Reset: clear = 1 for one edge with ConIn = 1, IRout = 0, BusMuxOut = 0 → ConFFOut = 0. Then clear = 0, ConIn = 0, inputs changed → ConFFOut stays 0.
- brzr: IRout = 32'h0.
  - ConIn pulse with BusMuxOut = 32'h0 → ConFFOut = 1.
  - ConIn pulse with BusMuxOut = 32'h1 → ConFFOut = 0.
- brnz: IRout = 32'h98080000.
  - BusMuxOut = 32'h0000FFFF → ConFFOut = 1.
  - BusMuxOut = 32'h0 → ConFFOut = 0.
- brpl: IRout = 32'h98100000.
  - BusMuxOut = 32'h0000FFFF → ConFFOut = 1.
  - BusMuxOut = 32'hFFFF0000 → ConFFOut = 0.
  - BusMuxOut = 0 → ConFFOut = 1.
- brmi: IRout = 32'h98180000.
  - BusMuxOut = 32'hFFFF0000 → ConFFOut = 1.
  - BusMuxOut = 32'h0000FFFF → ConFFOut = 0.
- Hold and priority:
  - After loading 1, drop ConIn and change the bus to 32'hF → ConFFOut stays 1 for several cycles.
  - clear and ConIn high together with a true condition → ConFFOut = 0.

Source files
------------

// File: rtl/con_ff_logic_pkg.sv
// Shared CPU constants for the branch-condition logic: C2 encodings,
// instruction-register field positions and datapath width.
package con_ff_logic_pkg;

    localparam int DATA_W = 32;

    // Position of the C2 branch-condition field inside the instruction register
    localparam int C2_HI = 20;
    localparam int C2_LO = 19;
    localparam int C2_W  = C2_HI - C2_LO + 1;

    // Branch condition encodings carried in C2
    typedef enum logic [1:0] {
        BR_ZR = 2'b00,  // branch if register is zero
        BR_NZ = 2'b01,  // branch if register is non-zero
        BR_PL = 2'b10,  // branch if register is non-negative
        BR_MI = 2'b11   // branch if register is negative
    } br_cond_e;

    // Pull the C2 field out of a full instruction word
    function automatic logic [C2_W-1:0] c2_field(input logic [DATA_W-1:0] ir);
        return ir[C2_HI:C2_LO];
    endfunction

endpackage

// File: rtl/decoder_2to4.sv
// Generic 2-to-4 one-hot decoder; also used elsewhere in the control path.
module decoder_2to4 (
    input  logic [1:0] sel,
    output logic [3:0] onehot
);

    // One output line per select code, active when the code matches
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_line
            assign onehot[gi] = (sel == 2'(gi));
        end
    endgenerate

endmodule

// File: rtl/con_ff_logic.sv
// CON FF: evaluates the C2 branch condition of the current instruction
// against the register value on the bus and latches the one-bit decision
// the control unit uses to decide whether the PC takes the branch target.
module con_ff_logic
    import con_ff_logic_pkg::*;
(
    input  logic              clock,
    input  logic              clear,
    input  logic              ConIn,
    input  logic [DATA_W-1:0] IRout,
    input  logic [DATA_W-1:0] BusMuxOut,
    output logic              ConFFOut
);

    logic [C2_W-1:0]   c2;
    logic [3:0]        cond_line;
    logic [3:0]        cond_true;
    logic [DATA_W-1:0] or_chain;
    logic              bus_zero;
    logic              bus_sign;
    logic              take_branch;
    logic              con_reg;
    logic              con_next;

    // Only C2 steers the decision; the rest of the instruction word is
    // deliberately ignored, gathered here so it is visibly accounted for.
    logic unused_ir_bits;
    assign unused_ir_bits = ^{IRout[DATA_W-1:C2_HI+1], IRout[C2_LO-1:0]};

    assign c2 = c2_field(IRout);

    decoder_2to4 u_c2_dec (
        .sel    (c2),
        .onehot (cond_line)
    );

    // Zero detect as a NOR of every bus bit, built as a ripple OR chain
    assign or_chain[0] = BusMuxOut[0];
    generate
        for (genvar gi = 1; gi < DATA_W; gi++) begin : g_zero
            assign or_chain[gi] = or_chain[gi-1] | BusMuxOut[gi];
        end
    endgenerate
    assign bus_zero = ~or_chain[DATA_W-1];

    // Sign tap: zero counts as non-negative
    assign bus_sign = BusMuxOut[DATA_W-1];

    // Per-encoding condition, indexed by the C2 code that selects it
    always_comb begin
        cond_true        = '0;
        cond_true[BR_ZR] = bus_zero;
        cond_true[BR_NZ] = ~bus_zero;
        cond_true[BR_PL] = ~bus_sign;
        cond_true[BR_MI] = bus_sign;
    end

    // AND-OR select: exactly one decoder line is active
    assign take_branch = |(cond_line & cond_true);

    // Next-state: clear beats load, load beats hold
    always_comb begin
        con_next = con_reg;
        if (clear) begin
            con_next = 1'b0;
        end else if (ConIn) begin
            con_next = take_branch;
        end
    end

    // Decision flip-flop
    always_ff @(posedge clock) begin
        con_reg <= con_next;
    end

    assign ConFFOut = con_reg;

endmodule

// File: tb/tb_con_ff_logic.sv
// Self-checking bench for con_ff_logic: directed branch scenarios followed
// by randomized traffic compared against a behavioural reference.
module tb_con_ff_logic;

    logic        clock;
    logic        clear;
    logic        ConIn;
    logic [31:0] IRout;
    logic [31:0] BusMuxOut;
    logic        ConFFOut;

    int vectors;
    int miscompares;
    bit exp_out;

    con_ff_logic dut (
        .clock     (clock),
        .clear     (clear),
        .ConIn     (ConIn),
        .IRout     (IRout),
        .BusMuxOut (BusMuxOut),
        .ConFFOut  (ConFFOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference decision from the branch rules, treating the bus as a
    // signed integer for the sign tests.
    function automatic bit ref_take(input logic [31:0] ir, input logic [31:0] bus);
        int signed v;
        int        code;
        v    = $signed(bus);
        code = int'(ir[20]) * 2 + int'(ir[19]);
        case (code)
            0:       return bus == 0;
            1:       return bus != 0;
            2:       return v >= 0;
            default: return v < 0;
        endcase
    endfunction

    // Apply one cycle of inputs, advance the model, check after the edge
    task automatic step(input bit clr, input bit con, input logic [31:0] ir,
                        input logic [31:0] bus, input string tag);
        @(negedge clock);
        clear     = clr;
        ConIn     = con;
        IRout     = ir;
        BusMuxOut = bus;
        @(posedge clock);
        if (clr)      exp_out = 1'b0;
        else if (con) exp_out = ref_take(ir, bus);
        #1;
        vectors++;
        assert (ConFFOut === exp_out)
        else begin
            miscompares++;
            $error("FAIL %s: clr=%0b con=%0b ir=%h bus=%h observed=%0b expected=%0b",
                   tag, clr, con, ir, bus, ConFFOut, exp_out);
        end
        $display("vec %0d %s clr=%0b con=%0b ir=%h bus=%h out=%0b", vectors, tag,
                 clr, con, ir, bus, ConFFOut);
    endtask

    initial begin
        logic [31:0] ir;
        logic [31:0] bus;
        bit          clr;
        bit          con;
        vectors     = 0;
        miscompares = 0;
        exp_out     = 1'b0;
        clear       = 1'b1;
        ConIn       = 1'b1;
        IRout       = '0;
        BusMuxOut   = '0;

        // Reset, then ignored input changes while not loading
        step(1, 1, 32'h0, 32'h0, "reset");
        step(0, 0, 32'h98100000, 32'h0, "idle_after_reset");

        // brzr
        step(0, 1, 32'h0, 32'h0, "brzr_zero");
        step(0, 1, 32'h0, 32'h1, "brzr_one");
        // brnz
        step(0, 1, 32'h98080000, 32'h0000FFFF, "brnz_nonzero");
        step(0, 1, 32'h98080000, 32'h0, "brnz_zero");
        // brpl
        step(0, 1, 32'h98100000, 32'h0000FFFF, "brpl_pos");
        step(0, 1, 32'h98100000, 32'hFFFF0000, "brpl_neg");
        step(0, 1, 32'h98100000, 32'h0, "brpl_zero");
        // brmi
        step(0, 1, 32'h98180000, 32'hFFFF0000, "brmi_neg");
        step(0, 1, 32'h98180000, 32'h0000FFFF, "brmi_pos");

        // Hold: load 1, then change bus with ConIn low
        step(0, 1, 32'h98180000, 32'h80000000, "hold_load");
        for (int i = 0; i < 4; i++)
            step(0, 0, 32'h98180000, 32'hF, "hold");

        // Clear beats load with a true condition
        step(0, 1, 32'h0, 32'h0, "prio_load");
        step(1, 1, 32'h0, 32'h0, "prio_clear");

        // Continuous load tracks inputs
        step(0, 1, 32'h98080000, 32'h5, "track_a");
        step(0, 1, 32'h98080000, 32'h0, "track_b");
        step(0, 1, 32'h98080000, 32'h7, "track_c");

        // Randomized traffic, unused IR bits randomized too
        for (int i = 0; i < 300; i++) begin
            ir  = $urandom;
            case ($urandom_range(0, 3))
                0:       bus = 32'h0;
                1:       bus = 32'h80000000 | 32'($urandom);
                2:       bus = 32'h7FFFFFFF & 32'($urandom);
                default: bus = $urandom;
            endcase
            clr = ($urandom_range(0, 15) == 0);
            con = $urandom_range(0, 1) == 1;
            step(clr, con, ir, bus, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
